devtbl_gen: RTL
===============

# devtbl_gen

Parametrised device-table and reset controller. It serves the boot-time device enumeration table for any number of devices, and drives per-core reset lines for up to NCORE cores, with timed reset pulses and an optional watchdog. It sits on the pi1 peripheral bus at the device-table slot and feeds the per-core reset inputs and the preloader-disable strobe.

## Interface

Parameters:
- ARCHBITSZ, 32: bus data width; 32 or 64.
- NDEV, 6: number of table entries; 1..64.
- DEVID, 0: NDEV×8 packed device IDs; entry k is at [8k+7:8k].
- DEVMAPSZ, 0: NDEV×ADDRBITSZ packed map sizes, in ARCHBITSZ/8-byte units.
- DEVINTR, 0: NDEV bits; bit k=1 means entry k uses an interrupt.
- NCORE, 2: number of reset outputs; 1..16.
- RSTCYCLES, 16: timed reset pulse length in cycles; ≥1.
- SOCVERSION, 0 / RAMCACHESZ, 0 / PRELDRADDR, 0: query constants.
- Derived: ADDRBITSZ = ARCHBITSZ − clog2(ARCHBITSZ/8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- rst_o  out  NCORE  per-core reset, active-high
- preldrdis_o  out  1  one-cycle strobe when the preloader is disabled
- pi1_op_i  in  2  00 noop, 01 wr, 10 rd, 11 rw
- pi1_addr_i  in  ADDRBITSZ  word address
- pi1_data_i  in  ARCHBITSZ  write/command data
- pi1_data_o  out  ARCHBITSZ  registered read data
- pi1_sel_i  in  ARCHBITSZ/8  byte select; ignored
- pi1_rdy_o  out  1  constant 1
- pi1_mapsz_o  out  ADDRBITSZ  constant ((4096−512)/(ARCHBITSZ/8)) − 4

## Operation

- Reset values: rst_o=0, pi1_data_o=0, preldrdis_o=0, pulse FSM IDLE, hold mask 0, preloader-disabled flag 0, watchdog disarmed.
- rd op:
  - Even address 2k returns DEVID entry k, zero-extended.
  - Odd address 2k+1 returns {DEVMAPSZ entry k, zeros, DEVINTR bit k}.
  - k ≥ NDEV returns 0.
- rw at address 0 is a query; the selector is pi1_data_i:
  - 0: SOCVERSION
  - 1: RAMCACHESZ
  - 2: rst_o, zero-extended
  - 3: PRELDRADDR, or 0 once the preloader is disabled
  - 4: NDEV
  - 5: NCORE
  - 6: {watchdog-fired flag, FSM busy}
  - any other selector: 0
- rw at address 1 is a command. The command field is data_i[ARCHBITSZ−1:ARCHBITSZ−4]; the mask is data_i[NCORE−1:0]. Response is 0 when accepted, 1 when busy.
  - 0 HOLD: hold |= mask.
  - 1 RELEASE: hold &= ~mask.
  - 2 PULSE: if IDLE, latch the mask, load the counter with RSTCYCLES−1 and go to PULSE. If not IDLE, the command is ignored and returns busy.
  - 3 PRELDRDIS: set the sticky flag and pulse preldrdis_o for one cycle.
  - Any other command: no effect; response 0.
- Reset output: rst_o = hold | (FSM==PULSE ? pulsemask : 0), registered.
- Pulse FSM:
  - IDLE → PULSE on an accepted PULSE command.
  - In PULSE the counter decrements each cycle. At count 0 the FSM moves to IDLE and clears pulsemask.
  - The counter is clog2(RSTCYCLES+1) bits wide and never wraps.
- wr op and noop: no state change; pi1_data_o holds its value.
- An rw at any other address returns 0.

## Timing

- Every response is registered: pi1_data_o is valid on the cycle after the op is sampled.
- rst_o changes one cycle after command sampling.
- A PULSE command asserts rst_o on the mask for exactly RSTCYCLES cycles.
- HOLD issued during a pulse keeps those bits high after the pulse ends.
- RELEASE during a pulse clears hold only; the pulsed bits stay high until the pulse ends.
- Watchdog expiry and a PULSE command in the same cycle: the watchdog wins and uses the all-ones mask; the command returns busy.
- Asserting rst_i mid-pulse returns everything to reset values asynchronously.

## Configuration

- DEVTBL_WATCHDOG_EN defined:
  - An rw at address 2 with data ≠ 0 arms or kicks the watchdog: the 32-bit counter is loaded with the data value and the fired flag is cleared.
  - Data = 0 disarms it.
  - While armed, the counter decrements every cycle. On reaching 0 it disarms, sets the fired flag, and starts a PULSE on all cores. If the FSM is already busy, that pulse stays pending until IDLE.
  - The rw response is 0.
- Undefined: an rw at address 2 returns 0, there is no counter, and the fired flag reads 0.

## Structure

- Package devtbl_pkg holds:
  - the op encodings PINOOP, PIWROP, PIRDOP, PIRWOP;
  - the command codes;
  - the query selector codes;
  - the FSM state type.
- Sub-module devtbl_rstseq contains the hold mask, the pulse FSM and counter, and the pending-watchdog latch. It exposes cmd/mask/valid/busy and rst_o.

## Test plan

- rd at addr 2k and 2k+1 for all k < NDEV and for k = NDEV → each entry's ID and {mapsz, intr} match the parameters; the out-of-range entry reads 0.
- rw addr 1, PULSE mask 0b01 with RSTCYCLES=16 → rst_o[0] high for exactly 16 cycles. A second PULSE issued at cycle 5 returns 1 and does not extend the pulse.
- HOLD 0b10, then PULSE 0b11, then RELEASE 0b10 at cycle 3 → rst_o[1] drops at cycle 16; rst_o[0] also drops at 16.
- rw addr 0 selector 3 → PRELDRADDR. After PRELDRDIS: preldrdis_o is high for one cycle and selector 3 reads 0.
- With DEVTBL_WATCHDOG_EN: arm with 100 and kick at cycle 50 → no reset by cycle 120. Without a kick → all rst_o high at cycle 101 for RSTCYCLES cycles, and selector 6 bit1 = 1.
- Assert rst_i mid-pulse → rst_o is 0 immediately and the FSM is IDLE. After release, a PULSE command is accepted with response 0.

Source files
------------

// File: rtl/devtbl_pkg.sv
// Shared encodings for devtbl_gen: pi1 bus ops, command codes, query selectors, pulse FSM states.
package devtbl_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    localparam logic [3:0] CMD_HOLD      = 4'd0;
    localparam logic [3:0] CMD_RELEASE   = 4'd1;
    localparam logic [3:0] CMD_PULSE     = 4'd2;
    localparam logic [3:0] CMD_PRELDRDIS = 4'd3;

    localparam logic [2:0] QRY_SOCVERSION = 3'd0;
    localparam logic [2:0] QRY_RAMCACHESZ = 3'd1;
    localparam logic [2:0] QRY_RSTOUT     = 3'd2;
    localparam logic [2:0] QRY_PRELDRADDR = 3'd3;
    localparam logic [2:0] QRY_NDEV       = 3'd4;
    localparam logic [2:0] QRY_NCORE      = 3'd5;
    localparam logic [2:0] QRY_STATUS     = 3'd6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } rst_state_t;

endpackage

// File: rtl/devtbl_rstseq.sv
// Per-core reset sequencer: hold mask, timed pulse FSM/counter, pending watchdog pulse.
// Latency: rst_o is registered and changes on the edge that samples the command.
// Backpressure: a PULSE while busy, or colliding with a watchdog pulse, is refused via cmd_busy.
module devtbl_rstseq #(
    parameter int NCORE     = 2,
    parameter int RSTCYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_vld,
    input  logic [3:0]       cmd_dat,
    input  logic [NCORE-1:0] cmd_mask,
    output logic             cmd_busy,
    input  logic             wdt_fire,
    output logic             busy,
    output logic [NCORE-1:0] rst_o
);
    import devtbl_pkg::*;

    localparam int CW = $clog2(RSTCYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RSTCYCLES - 1);

    rst_state_t       state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [NCORE-1:0] hold_q, hold_nxt;
    logic [NCORE-1:0] pmask_q, pmask_nxt;
    logic [NCORE-1:0] rst_nxt;
    logic             pend_q, pend_nxt;
    logic             pulse_cmd;
    logic             wdt_req;

    assign pulse_cmd = cmd_vld && (cmd_dat == CMD_PULSE);
    assign wdt_req   = wdt_fire || pend_q;
    assign busy      = (state_q == ST_PULSE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            pmask_q <= '0;
            pend_q  <= 1'b0;
            rst_o   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            hold_q  <= hold_nxt;
            pmask_q <= pmask_nxt;
            pend_q  <= pend_nxt;
            rst_o   <= rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        hold_nxt  = hold_q;
        pmask_nxt = pmask_q;
        pend_nxt  = pend_q;
        // Watchdog pulse beats a command pulse issued in the same cycle.
        cmd_busy  = pulse_cmd && ((state_q != ST_IDLE) || wdt_req);

        if (cmd_vld && (cmd_dat == CMD_HOLD))
            hold_nxt = hold_q | cmd_mask;
        if (cmd_vld && (cmd_dat == CMD_RELEASE))
            hold_nxt = hold_q & ~cmd_mask;

        case (state_q)
            ST_IDLE: begin
                if (wdt_req) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = CNT_LOAD;
                    pmask_nxt = '1;
                    pend_nxt  = 1'b0;
                end else if (pulse_cmd) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = CNT_LOAD;
                    pmask_nxt = cmd_mask;
                end
            end
            ST_PULSE: begin
                if (wdt_fire)
                    pend_nxt = 1'b1;
                if (cnt_q == '0) begin
                    state_nxt = ST_IDLE;
                    pmask_nxt = '0;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        rst_nxt = hold_nxt | ((state_nxt == ST_PULSE) ? pmask_nxt : '0);
    end

endmodule

// File: rtl/devtbl_gen.sv
// Device-table server and per-core reset controller on pi1; DEVTBL_WATCHDOG_EN adds a watchdog.
// Latency: every response is registered, pi1_data_o valid the cycle after the op is sampled.
// Backpressure: none, pi1_rdy_o is tied high; a refused PULSE answers 1 instead of stalling.
module devtbl_gen #(
    parameter int ARCHBITSZ = 32,
    parameter int NDEV      = 6,
    parameter logic [NDEV*8-1:0] DEVID = '0,
    parameter logic [NDEV*(ARCHBITSZ-$clog2(ARCHBITSZ/8))-1:0] DEVMAPSZ = '0,
    parameter logic [NDEV-1:0] DEVINTR = '0,
    parameter int NCORE     = 2,
    parameter int RSTCYCLES = 16,
    parameter logic [ARCHBITSZ-1:0] SOCVERSION = '0,
    parameter logic [ARCHBITSZ-1:0] RAMCACHESZ = '0,
    parameter logic [ARCHBITSZ-1:0] PRELDRADDR = '0
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    output logic [NCORE-1:0]                                rst_o,
    output logic                                            preldrdis_o,
    input  logic [1:0]                                      pi1_op_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]        pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]                            pi1_data_i,
    output logic [ARCHBITSZ-1:0]                            pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0]                          pi1_sel_i,
    output logic                                            pi1_rdy_o,
    output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]        pi1_mapsz_o
);
    import devtbl_pkg::*;

    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
    localparam int KW        = ADDRBITSZ - 1;

    logic                 is_rw;
    logic                 cmd_vld;
    logic [3:0]           cmd_dat;
    logic                 cmd_busy;
    logic                 preldr_cmd;
    logic                 preldr_dis;
    logic                 seq_busy;
    logic                 wdt_fire;
    logic                 wdt_fired;
    logic [KW-1:0]        ent;
    logic [ARCHBITSZ-1:0] tbl_dat;
    logic [ARCHBITSZ-1:0] qry_dat;
    logic [ARCHBITSZ-1:0] rsp_nxt;
    logic                 unused_sel;

    assign pi1_rdy_o   = 1'b1;
    assign pi1_mapsz_o = ADDRBITSZ'((4096 - 512) / (ARCHBITSZ / 8) - 4);
    assign unused_sel  = ^pi1_sel_i;

    assign is_rw      = (pi1_op_i == PIRWOP);
    assign cmd_vld    = is_rw && (pi1_addr_i == ADDRBITSZ'(1));
    assign cmd_dat    = pi1_data_i[ARCHBITSZ-1 -: 4];
    assign preldr_cmd = cmd_vld && (cmd_dat == CMD_PRELDRDIS);
    assign ent        = pi1_addr_i[ADDRBITSZ-1:1];

    devtbl_rstseq #(
        .NCORE     (NCORE),
        .RSTCYCLES (RSTCYCLES)
    ) u_rstseq (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cmd_vld  (cmd_vld),
        .cmd_dat  (cmd_dat),
        .cmd_mask (pi1_data_i[NCORE-1:0]),
        .cmd_busy (cmd_busy),
        .wdt_fire (wdt_fire),
        .busy     (seq_busy),
        .rst_o    (rst_o)
    );

`ifdef DEVTBL_WATCHDOG_EN
    logic        wdt_wr;
    logic        wdt_arm;
    logic [31:0] wdt_cnt;

    assign wdt_wr = is_rw && (pi1_addr_i == ADDRBITSZ'(2));
    // A kick landing on the expiry cycle wins and re-arms instead of firing.
    assign wdt_fire = wdt_arm && (wdt_cnt <= 32'd1) && !wdt_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_arm   <= 1'b0;
            wdt_cnt   <= '0;
            wdt_fired <= 1'b0;
        end else if (wdt_wr) begin
            if (pi1_data_i != '0) begin
                wdt_cnt   <= pi1_data_i[31:0];
                wdt_arm   <= 1'b1;
                wdt_fired <= 1'b0;
            end else begin
                wdt_arm <= 1'b0;
            end
        end else if (wdt_fire) begin
            wdt_arm   <= 1'b0;
            wdt_cnt   <= '0;
            wdt_fired <= 1'b1;
        end else if (wdt_arm) begin
            wdt_cnt <= wdt_cnt - 32'd1;
        end
    end
`else
    assign wdt_fire  = 1'b0;
    assign wdt_fired = 1'b0;
`endif

    always_comb begin
        tbl_dat = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (ent == KW'(i)) begin
                if (pi1_addr_i[0])
                    tbl_dat = {DEVMAPSZ[i*ADDRBITSZ +: ADDRBITSZ],
                               {(ARCHBITSZ-ADDRBITSZ-1){1'b0}}, DEVINTR[i]};
                else
                    tbl_dat = ARCHBITSZ'(DEVID[i*8 +: 8]);
            end
        end
    end

    always_comb begin
        qry_dat = '0;
        if (pi1_data_i[ARCHBITSZ-1:3] == '0) begin
            case (pi1_data_i[2:0])
                QRY_SOCVERSION: qry_dat = SOCVERSION;
                QRY_RAMCACHESZ: qry_dat = RAMCACHESZ;
                QRY_RSTOUT:     qry_dat = ARCHBITSZ'(rst_o);
                QRY_PRELDRADDR: qry_dat = preldr_dis ? '0 : PRELDRADDR;
                QRY_NDEV:       qry_dat = ARCHBITSZ'(NDEV);
                QRY_NCORE:      qry_dat = ARCHBITSZ'(NCORE);
                QRY_STATUS:     qry_dat = ARCHBITSZ'({wdt_fired, seq_busy});
                default:        qry_dat = '0;
            endcase
        end
    end

    always_comb begin
        rsp_nxt = pi1_data_o;
        case (pi1_op_i)
            PIRDOP: rsp_nxt = tbl_dat;
            PIRWOP: begin
                if (pi1_addr_i == ADDRBITSZ'(0))
                    rsp_nxt = qry_dat;
                else if (pi1_addr_i == ADDRBITSZ'(1))
                    rsp_nxt = ARCHBITSZ'(cmd_busy);
                else
                    rsp_nxt = '0;
            end
            PIWROP, PINOOP: rsp_nxt = pi1_data_o;
            default: rsp_nxt = pi1_data_o;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pi1_data_o  <= '0;
            preldrdis_o <= 1'b0;
            preldr_dis  <= 1'b0;
        end else begin
            pi1_data_o  <= rsp_nxt;
            preldrdis_o <= preldr_cmd;
            if (preldr_cmd)
                preldr_dis <= 1'b1;
        end
    end

endmodule
